// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer between imem req/gnt port and prefetch FIFO.
// Optional perf counters are enabled by defining FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = 32'h1000_0000,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  input  logic            fifo_ready_i,
  output logic            fifo_clear_o,
  output logic            fifo_valid_o,
  output logic [XLEN-1:0] fifo_addr_o,
  output logic [XLEN-1:0] fifo_instr_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            busy_o
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_req_o,
  output logic [31:0]     perf_drop_o,
  output logic [31:0]     perf_stall_o
`endif
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH,
    HALT
  } state_e;

  localparam logic [1:0] MAX_O = 2'(MAX_OUTSTANDING);

  state_e          state_q;
  state_e          resume;
  logic [XLEN-1:0] pc_q;
  logic            off_q;
  logic [1:0]      out_q;
  logic [1:0]      out_d;
  logic [1:0]      stale_q;
  logic [1:0]      stale_d;
  logic [1:0]      wr_idx;
  logic [XLEN-1:0] tq_q [MAX_OUTSTANDING];
  logic [XLEN-1:0] tq_d [MAX_OUTSTANDING];
  logic [XLEN-1:0] tag;
  logic            redir;
  logic            rv_ok;
  logic            accept;
  logic            drop;
  logic            fire;
  logic            unused_pc_lsb;

  assign unused_pc_lsb = redirect_pc_i[0];

  assign redir  = redirect_i & (state_q != BOOT);
  assign rv_ok  = imem_rvalid_i & (out_q != 2'd0);
  assign accept = rv_ok & (stale_q == 2'd0) & ~redir;
  assign drop   = rv_ok & ~accept;

  assign imem_req_o = (state_q == RUN) & fifo_ready_i
                    & ~redirect_i & (out_q < MAX_O);
  assign fire        = imem_req_o & imem_gnt_i;
  assign imem_addr_o = pc_q;
  assign tag         = {pc_q[XLEN-1:2], off_q, 1'b0};

  assign fifo_clear_o = redir;
  assign fifo_valid_o = accept;
  assign fifo_addr_o  = accept ? tq_q[0] : '0;
  assign fifo_instr_o = accept ? imem_rdata_i : '0;
  assign busy_o       = out_q != 2'd0;

  assign resume = halt_i ? HALT : RUN;

  // Tag queue occupancy always equals the outstanding count.
  always_comb begin
    out_d   = out_q + {1'b0, fire} - {1'b0, rv_ok};
    stale_d = stale_q;
    if (redir) stale_d = out_q - {1'b0, rv_ok};
    else if (drop) stale_d = stale_q - 2'd1;
    wr_idx = out_q - {1'b0, rv_ok};
    tq_d   = tq_q;
    if (rv_ok) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING) - 1; i++)
        tq_d[i] = tq_q[i+1];
    end
    if (fire) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++)
        if (wr_idx == 2'(i)) tq_d[i] = tag;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      off_q   <= 1'b0;
      out_q   <= 2'd0;
      stale_q <= 2'd0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++)
        tq_q[i] <= '0;
    end else begin
      out_q   <= out_d;
      stale_q <= stale_d;
      tq_q    <= tq_d;
      if (redir) begin
        pc_q  <= {redirect_pc_i[XLEN-1:2], 2'b00};
        off_q <= redirect_pc_i[1];
      end else if (fire) begin
        pc_q  <= pc_q + XLEN'(4);
        off_q <= 1'b0;
      end
      unique case (1'b1)
        state_q == BOOT:
          state_q <= resume;
        redir:
          state_q <= (stale_d != 2'd0) ? FLUSH : resume;
        state_q == FLUSH && !redir:
          if (stale_d == 2'd0) state_q <= resume;
        default:
          state_q <= resume;
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_req_q;
  logic [31:0] perf_drop_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_req_q   <= '0;
      perf_drop_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (fire) perf_req_q <= perf_req_q + 32'd1;
      if (drop) perf_drop_q <= perf_drop_q + 32'd1;
      if (state_q == RUN && !fifo_ready_i)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_req_o   = perf_req_q;
  assign perf_drop_o  = perf_drop_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus, queue-based reference model and
// literal checks for fetch_ctrl.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] rpc = '0;
  logic        halt = 1'b0;
  logic        ready = 1'b1;
  logic        gnt = 1'b1;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        fclear, fvalid, req, busy;
  logic [31:0] faddr, finstr, iaddr;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_req, perf_drop, perf_stall;
`endif

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .redirect_i   (redirect),
    .redirect_pc_i(rpc),
    .halt_i       (halt),
    .fifo_ready_i (ready),
    .fifo_clear_o (fclear),
    .fifo_valid_o (fvalid),
    .fifo_addr_o  (faddr),
    .fifo_instr_o (finstr),
    .imem_req_o   (req),
    .imem_addr_o  (iaddr),
    .imem_gnt_i   (gnt),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i (rdata),
    .busy_o       (busy)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_req_o   (perf_req),
    .perf_drop_o  (perf_drop),
    .perf_stall_o (perf_stall)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] tag;
    bit          stale;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_off, m_boot, m_go;
  int          m_req, m_drop, m_stall;

  initial begin
    bit redir, e_req, e_push, grant, any_stale;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        m_pc = 32'h1000_0000;
        m_off = 0; m_boot = 1; m_go = 0;
        m_req = 0; m_drop = 0; m_stall = 0;
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_addr", iaddr, 32'h1000_0000);
        chk("rst_valid", {31'd0, fvalid}, 32'd0);
        chk("rst_clear", {31'd0, fclear}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_faddr", faddr, 32'd0);
        chk("rst_finstr", finstr, 32'd0);
      end else begin
        redir  = redirect && !m_boot;
        e_req  = m_go && ready && !redirect && mq.size() < 2;
        e_push = rvalid && mq.size() > 0 && !mq[0].stale && !redir;
        chk("req", {31'd0, req}, {31'd0, e_req});
        chk("addr", iaddr, m_pc);
        chk("clear", {31'd0, fclear}, {31'd0, redir});
        chk("busy", {31'd0, busy}, {31'd0, mq.size() != 0});
        chk("push", {31'd0, fvalid}, {31'd0, e_push});
        if (e_push) begin
          chk("push_addr", faddr, mq[0].tag);
          chk("push_instr", finstr, ~{mq[0].tag[31:2], 2'b00});
        end
      end
      @(posedge clk);
      if (rst_n) begin
        redir = redirect && !m_boot;
        grant = m_go && ready && !redirect && mq.size() < 2 && gnt;
        if (m_go && !ready) m_stall++;
        if (rvalid && mq.size() > 0) begin
          if (mq[0].stale || redir) m_drop++;
          void'(mq.pop_front());
        end
        if (grant) begin
          mq.push_back('{tag: {m_pc[31:2], m_off, 1'b0}, stale: 1'b0});
          m_pc = m_pc + 32'd4;
          m_off = 0;
          m_req++;
        end
        if (redir) begin
          foreach (mq[i]) mq[i].stale = 1;
          m_pc = {rpc[31:2], 2'b00};
          m_off = rpc[1];
        end
        any_stale = 0;
        foreach (mq[i]) if (mq[i].stale) any_stale = 1;
        m_go = !any_stale && !halt;
        m_boot = 0;
      end
    end
  end

  // ---------------- logs for literal checks ----------------
  int          cyc = 0;
  int          first_req = -1;
  int          req_cnt = 0;
  int          push_cnt = 0;
  logic [31:0] req_log[$];
  logic [31:0] push_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (req) req_cnt++;
      if (fvalid) begin
        push_cnt++;
        push_log.push_back(faddr);
      end
      if (req && gnt) begin
        req_log.push_back(iaddr);
        if (first_req < 0) first_req = cyc;
      end
    end
  end

  function automatic logic [31:0] req_at(int i);
    return (req_log.size() > i) ? req_log[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] push_at(int i);
    return (push_log.size() > i) ? push_log[i] : 32'hxxxx_xxxx;
  endfunction

  // ---------------- memory responder ----------------
  typedef struct {
    logic [31:0] a;
    int          t;
  } rsp_t;

  rsp_t rsp_q[$];
  bit   rsp_en = 1;
  bit   inj = 0;
  bit   inj_active = 0;
  int   lat = 1;
  int   rcyc = 0;

  initial begin
    bit          g, rv;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      g = rst_n && req && gnt;
      a = iaddr;
      rv = rvalid;
      @(posedge clk);
      rcyc++;
      if (!rst_n) rsp_q.delete();
      else begin
        if (rv && !inj_active && rsp_q.size() > 0) void'(rsp_q.pop_front());
        if (g) rsp_q.push_back('{a: a, t: rcyc});
      end
      #2;
      if (inj) begin
        rvalid = 1; rdata = 32'hDEAD_BEEF;
        inj = 0; inj_active = 1;
      end else if (rsp_en && rsp_q.size() > 0 &&
                   rcyc - rsp_q[0].t + 1 >= lat) begin
        rvalid = 1; rdata = ~rsp_q[0].a;
        inj_active = 0;
      end else begin
        rvalid = 0; rdata = '0;
        inj_active = 0;
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete();
    push_log.delete();
    req_cnt = 0;
    push_cnt = 0;
  endtask

  initial begin
    int rel;
    step(2);
    rst_n = 1;
    rel = cyc;
    // streaming fetch, gnt always high, 1-cycle response
    step(10);
    chk("first_req_cyc", first_req, rel + 1);
    chk("p1_req0", req_at(0), 32'h1000_0000);
    chk("p1_req1", req_at(1), 32'h1000_0004);
    chk("p1_req2", req_at(2), 32'h1000_0008);
    chk("p1_push0", push_at(0), 32'h1000_0000);
    chk("p1_push1", push_at(1), 32'h1000_0004);
    chk("p1_push2", push_at(2), 32'h1000_0008);
    // FIFO not ready: in-flight responses still pushed
    rsp_en = 0;
    step(3);
    ready = 0; rsp_en = 1;
    clear_logs();
    step(5);
    chk("nrdy_reqs", req_cnt, 0);
    chk("nrdy_pushes", push_cnt, 2);
    ready = 1;
    @(negedge clk);
    chk("nrdy_resume", {31'd0, req}, 32'd1);
    // redirect to halfword target with 2 outstanding
    step(1);
    rsp_en = 0;
    step(3);
    redirect = 1; rpc = 32'h2000_0006;
    clear_logs();
    @(negedge clk);
    chk("rd_clear", {31'd0, fclear}, 32'd1);
    step(1);
    redirect = 0; rsp_en = 1;
    step(8);
    chk("rd_req0", req_at(0), 32'h2000_0004);
    chk("rd_push0", push_at(0), 32'h2000_0006);
    chk("rd_push1", push_at(1), 32'h2000_0008);
    // redirect coinciding with the only response
    gnt = 0;
    step(6);
    gnt = 1;
    step(1);
    gnt = 0; rsp_en = 0;
    step(2);
    redirect = 1; rpc = 32'h3000_0000; rsp_en = 1;
    @(negedge clk);
    chk("rdrv_rvalid", {31'd0, rvalid}, 32'd1);
    chk("rdrv_nopush", {31'd0, fvalid}, 32'd0);
    step(1);
    redirect = 0; gnt = 1;
    @(negedge clk);
    chk("rdrv_req", {31'd0, req}, 32'd1);
    chk("rdrv_addr", iaddr, 32'h3000_0000);
    // halt with one outstanding, redirect while halted
    step(1);
    gnt = 0;
    step(4);
    gnt = 1;
    step(1);
    gnt = 0; rsp_en = 0; halt = 1;
    step(2);
    rsp_en = 1; gnt = 1;
    clear_logs();
    step(6);
    chk("halt_pushes", push_cnt, 1);
    chk("halt_reqs", req_cnt, 0);
    redirect = 1; rpc = 32'h4000_0000;
    step(1);
    redirect = 0;
    step(3);
    chk("halt_rd_reqs", req_cnt, 0);
    chk("halt_rd_addr", iaddr, 32'h4000_0000);
    halt = 0;
    step(1);
    @(negedge clk);
    chk("unhalt_req", {31'd0, req}, 32'd1);
    chk("unhalt_addr", iaddr, 32'h4000_0000);
    // address wrap
    step(1);
    redirect = 1; rpc = 32'hFFFF_FFFC;
    clear_logs();
    step(1);
    redirect = 0;
    step(8);
    chk("wrap_req0", req_at(0), 32'hFFFF_FFFC);
    chk("wrap_req1", req_at(1), 32'h0000_0000);
    // reset mid-flight, boot redirect, protocol-error response
    rsp_en = 0;
    step(2);
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_addr", iaddr, 32'h1000_0000);
    step(2);
    rst_n = 1; redirect = 1; rpc = 32'h5000_0000;
    gnt = 0; rsp_en = 1;
    @(negedge clk);
    chk("boot_rd_clear", {31'd0, fclear}, 32'd0);
    step(1);
    redirect = 0; inj = 1;
    @(negedge clk);
    chk("perr_rvalid", {31'd0, rvalid}, 32'd1);
    chk("perr_nopush", {31'd0, fvalid}, 32'd0);
    chk("perr_busy", {31'd0, busy}, 32'd0);
    step(1);
    gnt = 1;
    clear_logs();
    step(4);
    chk("boot_rd_req0", req_at(0), 32'h1000_0000);
    chk("boot_rd_req1", req_at(1), 32'h1000_0004);
`ifdef FETCH_CTRL_PERF_EN
    @(negedge clk);
    chk("perf_req", perf_req, m_req);
    chk("perf_drop", perf_drop, m_drop);
    chk("perf_stall", perf_stall, m_stall);
`endif
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
